// File: rtl/calc_disp_pkg.sv
// Shared constants, converter state encoding and digit helpers for the calculator display.
package calc_disp_pkg;
  localparam int          NUM_DIGITS = 4;
  localparam int          BIN_W      = 14;
  localparam int          BCD_W      = 16;
  localparam logic [13:0] MAX_VAL    = 14'd9999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit idx is a leading zero when it and every higher digit are zero; ones never blanks.
  function automatic logic lz_blank(input logic [BCD_W-1:0] d, input logic [1:0] idx);
    return (idx != 2'd0) && ((d >> {idx, 2'b00}) == '0);
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Serial binary-to-BCD converter, one shift per clock; commit strobe 15 cycles after accept.
// load_i is taken only while ready_o=1; requests during a conversion are dropped.
module bin2bcd_seq
  import calc_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             ovf_o,
  output logic             commit_o
);

  conv_state_t            state_q, state_d;
  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [3:0]             cnt_q;
  logic                   ovf_q;
  logic [BCD_W+BIN_W-1:0] shifted;

  assign shifted = {dd_adjust(bcd_q), bin_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    commit_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (load_i) state_d = SHIFT;
      end
      SHIFT: if (cnt_q == 4'd1) state_d = DONE;
      DONE: begin
        commit_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && load_i) begin
      bin_q <= value_i;
      bcd_q <= '0;
      cnt_q <= 4'd14;
      ovf_q <= (value_i > MAX_VAL);
    end else if (state_q == SHIFT) begin
      {bcd_q, bin_q} <= shifted;
      cnt_q          <= cnt_q - 4'd1;
    end
  end

  // Out-of-range values leave garbage in the scratch register; saturate instead.
  assign bcd_o = ovf_q ? 16'h9999 : bcd_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-seg sequencer: converts results to BCD and scans one digit per slot.
// Outputs registered one cycle behind scan index; new value accepted only when ready_o=1.
module display_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic             overflow_o,
  output logic [3:0]       digit_o,
  output logic [3:0]       an_o
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]    cnt_q;
  logic [1:0]       idx_q;
  logic [BCD_W-1:0] disp_q;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_ovf;
  logic             conv_commit;
  logic             blank;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_i  (value_i),
    .load_i   (load_i),
    .ready_o  (ready_o),
    .bcd_o    (conv_bcd),
    .ovf_o    (conv_ovf),
    .commit_o (conv_commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // All four digits land together so the scan never shows a mix of old and new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      overflow_o <= 1'b0;
    end else if (conv_commit) begin
      disp_q     <= conv_bcd;
      overflow_o <= conv_ovf;
    end
  end

  assign blank = BLANK_LZ && lz_blank(disp_q, idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o    <= 4'b1111;
      digit_o <= 4'd0;
    end else if (blank) begin
      an_o    <= 4'b1111;
      digit_o <= 4'd0;
    end else begin
      an_o    <= ~(4'b0001 << idx_q);
      digit_o <= disp_q[{idx_q, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=4; one instance per blanking mode.
module tb_display_scan_ctrl;

  typedef logic [3:0] samp_t [16];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value_i;
  logic        load_i;
  logic        ready0, ovf0, ready1, ovf1;
  logic [3:0]  dig0, an0, dig1, an1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .ready_o(ready0), .overflow_o(ovf0), .digit_o(dig0), .an_o(an0)
  );

  display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .ready_o(ready1), .overflow_o(ovf1), .digit_o(dig1), .an_o(an1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready0 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check({tag, "_ready_timeout"}, 32'(ready0), 32'd1);
  endtask

  // Accepts v on the next edge and returns how many cycles ready stayed low.
  task automatic do_load(input string tag, input logic [13:0] v, output int low);
    wait_ready(tag);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    low    = 0;
    while (ready0 !== 1'b1 && low < 64) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic analyze(input string tag, input samp_t an, input samp_t dg,
                         input logic [15:0] exp_d, input logic [3:0] exp_lit);
    int   lit [4];
    logic [3:0] dv [4];
    int   bad;
    int   s;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      lit[k] = 0;
      dv[k]  = 4'd0;
    end
    for (int i = 0; i < 16; i++) begin
      case (an[i])
        4'b1110: s = 0;
        4'b1101: s = 1;
        4'b1011: s = 2;
        4'b0111: s = 3;
        4'b1111: s = -1;
        default: s = -2;
      endcase
      if (s == -2) bad++;
      else if (s == -1) begin
        if (dg[i] !== 4'd0) bad++;
      end else begin
        if (lit[s] == 0) dv[s] = dg[i];
        else if (dv[s] !== dg[i]) bad++;
        lit[s]++;
      end
      if (i > 0 && an[i] != an[i-1] && an[i] != 4'b1111 && an[i-1] != 4'b1111 &&
          an[i] != {an[i-1][2:0], an[i-1][3]}) bad++;
    end
    check({tag, "_scan_errors"}, 32'(bad), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_lit%0d", tag, k), 32'(lit[k]), exp_lit[k] ? 32'd4 : 32'd0);
      if (exp_lit[k]) check($sformatf("%s_dig%0d", tag, k), 32'(dv[k]), 32'(exp_d[4*k +: 4]));
    end
  endtask

  task automatic scan(input string tag, input logic [15:0] d0, input logic [3:0] l0,
                      input logic [15:0] d1, input logic [3:0] l1);
    samp_t a0, g0, a1, g1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      a0[i] = an0; g0[i] = dig0;
      a1[i] = an1; g1[i] = dig1;
      @(negedge clk);
    end
    analyze({tag, "_lz1"}, a0, g0, d0, l0);
    analyze({tag, "_lz0"}, a1, g1, d1, l1);
  endtask

  initial begin
    int low;
    rst_n   = 1'b0;
    load_i  = 1'b0;
    value_i = 14'd0;
    repeat (3) @(negedge clk);
    check("rst_an",    32'(an0),    32'hF);
    check("rst_digit", 32'(dig0),   32'h0);
    check("rst_ready", 32'(ready0), 32'h1);
    check("rst_ovf",   32'(ovf0),   32'h0);
    check("rst_an_lz0", 32'(an1),   32'hF);

    rst_n = 1'b1;
    @(negedge clk);
    check("rel_an",        32'(an0),  32'hE);
    check("rel_digit",     32'(dig0), 32'h0);
    check("rel_an_lz0",    32'(an1),  32'hE);

    do_load("l1234", 14'd1234, low);
    check("l1234_ready_low", 32'(low), 32'd15);
    scan("l1234", 16'h1234, 4'b1111, 16'h1234, 4'b1111);

    do_load("l7", 14'd7, low);
    scan("l7", 16'h0007, 4'b0001, 16'h0007, 4'b1111);

    do_load("l12000", 14'd12000, low);
    check("l12000_ovf", 32'(ovf0), 32'd1);
    check("l12000_ovf_lz0", 32'(ovf1), 32'd1);
    scan("l12000", 16'h9999, 4'b1111, 16'h9999, 4'b1111);

    do_load("l0", 14'd0, low);
    check("l0_ovf", 32'(ovf0), 32'd0);
    scan("l0", 16'h0000, 4'b0001, 16'h0000, 4'b1111);

    // Second request arrives three edges after the first is accepted.
    wait_ready("l5678");
    value_i = 14'd5678;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    value_i = 14'd42;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    check("l42_busy", 32'(ready0), 32'd0);
    wait_ready("l5678");
    scan("l5678", 16'h5678, 4'b1111, 16'h5678, 4'b1111);

    // Reset in the middle of a conversion must not commit anything.
    wait_ready("l9999");
    value_i = 14'd9999;
    load_i  = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_an",    32'(an0),    32'hF);
    check("mid_rst_digit", 32'(dig0),   32'h0);
    check("mid_rst_ready", 32'(ready0), 32'h1);
    check("mid_rst_ovf",   32'(ovf0),   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_ready", 32'(ready0), 32'h1);
    scan("post_rst", 16'h0000, 4'b0001, 16'h0000, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
